// File: rtl/alu_operand_sequencer.sv
// Button/switch front end for the combinational ALU: synchronizes and debounces the
// buttons, loads A, B and Op in order, then captures one ALU result for display.
module alu_operand_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        A_button,
    input  logic        B_button,
    input  logic        Op_button,
    input  logic        cin,
    input  logic [9:0]  data_in,
    input  logic [15:0] alu_out,
    input  logic [4:0]  alu_flags,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [7:0]  Op,
    output logic        cin_q,
    output logic [15:0] result,
    output logic [4:0]  flags,
    output logic        result_valid,
    output logic        done,
    output logic [2:0]  state
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        StA    = 3'd0,
        StB    = 3'd1,
        StOp   = 3'd2,
        StExec = 3'd3,
        StShow = 3'd4
    } state_e;

    // Buttons are normalised to 1 = pressed before synchronizing, so reset value 0 is "released".
    logic [2:0] btn_raw;
    assign btn_raw = {Op_button, B_button, A_button} ^ {3{BUTTON_ACTIVE_LOW}};

    logic [2:0]           btn_meta_q, btn_sync_q;
    logic                 cin_meta_q, cin_sync_q;
    logic [9:0]           data_meta_q, data_sync_q;
    logic [2:0][CntW-1:0] cnt_q, cnt_d;
    logic [2:0]           db_q, db_d, press_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
            cin_meta_q  <= 1'b0;
            cin_sync_q  <= 1'b0;
            data_meta_q <= '0;
            data_sync_q <= '0;
        end else begin
            btn_meta_q  <= btn_raw;
            btn_sync_q  <= btn_meta_q;
            cin_meta_q  <= cin;
            cin_sync_q  <= cin_meta_q;
            data_meta_q <= data_in;
            data_sync_q <= data_meta_q;
        end
    end

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        for (int i = 0; i < 3; i++) begin
            if (btn_sync_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = btn_sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            db_q    <= '0;
            press_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            press_q <= db_d & ~db_q;
        end
    end

    logic   press_a, press_b, press_op;
    logic   a_load, b_load, op_load;
    state_e state_q, state_d;

    assign press_a  = press_q[0];
    assign press_b  = press_q[1];
    assign press_op = press_q[2];
    assign state    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StA;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StA:     if (press_a) state_d = StB;
            StB:     if (press_a) state_d = StB;
                     else if (press_b) state_d = StOp;
            StOp:    if (press_a) state_d = StB;
                     else if (press_op) state_d = StExec;
            StExec:  state_d = StShow;
            StShow:  if (press_a) state_d = StB;
            default: state_d = StA;
        endcase
    end

    always_comb begin
        a_load  = press_a && (state_q == StA || state_q == StB ||
                              state_q == StOp || state_q == StShow);
        b_load  = press_b && !press_a && (state_q == StB);
        op_load = press_op && !press_a && (state_q == StOp);
        done    = (state_q == StExec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A            <= '0;
            B            <= '0;
            Op           <= '0;
            cin_q        <= 1'b0;
            result       <= '0;
            flags        <= '0;
            result_valid <= 1'b0;
        end else if (a_load) begin
            A            <= {6'b0, data_sync_q};
            result_valid <= 1'b0;
        end else if (b_load) begin
            B <= {6'b0, data_sync_q};
        end else if (op_load) begin
            Op    <= data_sync_q[7:0];
            cin_q <= cin_sync_q;
        end else if (done) begin
            result       <= alu_out;
            flags        <= alu_flags;
            result_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed scenarios followed by random
// button sequences compared against a sequence-level reference model.
module tb_alu_operand_sequencer;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_pin, b_pin, op_pin, cin;
    logic [9:0]  data_in;
    logic [15:0] alu_out;
    logic [4:0]  alu_flags;
    logic [15:0] A, B, result;
    logic [7:0]  Op;
    logic        cin_q, result_valid, done;
    logic [4:0]  flags;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    // Reference model: the sequencer as seen from the operator's point of view
    logic [15:0] m_a, m_b, m_res;
    logic [7:0]  m_op;
    logic        m_cin, m_rv;
    logic [4:0]  m_flags;
    int          m_state;
    int          m_done = 0;

    alu_operand_sequencer #(
        .DEBOUNCE_CYCLES  (D),
        .BUTTON_ACTIVE_LOW(1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .A_button    (a_pin),
        .B_button    (b_pin),
        .Op_button   (op_pin),
        .cin         (cin),
        .data_in     (data_in),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags),
        .A           (A),
        .B           (B),
        .Op          (Op),
        .cin_q       (cin_q),
        .result      (result),
        .flags       (flags),
        .result_valid(result_valid),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Toy ALU: Op 0x02 adds with carry, anything else XORs operands and opcode
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [7:0] op, input logic c);
        if (op == 8'h02) return a + b + {15'b0, c};
        return a ^ b ^ {8'b0, op};
    endfunction

    function automatic logic [4:0] flags_fn(input logic [15:0] r, input logic c);
        return {r == 16'h0, r[15], 1'b0, c, 1'b0};
    endfunction

    assign alu_out   = alu_fn(A, B, Op, cin_q);
    assign alu_flags = flags_fn(alu_out, cin_q);

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".A"}, 32'(A), 32'(m_a));
        check({tag, ".B"}, 32'(B), 32'(m_b));
        check({tag, ".Op"}, 32'(Op), 32'(m_op));
        check({tag, ".cin_q"}, 32'(cin_q), 32'(m_cin));
        check({tag, ".state"}, 32'(state), 32'(m_state));
        check({tag, ".result"}, 32'(result), 32'(m_res));
        check({tag, ".flags"}, 32'(flags), 32'(m_flags));
        check({tag, ".valid"}, 32'(result_valid), 32'(m_rv));
        check({tag, ".done_count"}, 32'(done_cnt), 32'(m_done));
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_op = '0; m_cin = 1'b0;
        m_res = '0; m_flags = '0; m_rv = 1'b0; m_state = 0;
    endtask

    task automatic model_apply(input bit pa, input bit pb, input bit po,
                               input logic [9:0] d, input logic c);
        if (pa) begin
            m_a = {6'b0, d}; m_rv = 1'b0; m_state = 1;
        end else if (pb && m_state == 1) begin
            m_b = {6'b0, d}; m_state = 2;
        end else if (po && m_state == 2) begin
            m_op = d[7:0]; m_cin = c;
            m_res = alu_fn(m_a, m_b, m_op, m_cin);
            m_flags = flags_fn(m_res, m_cin);
            m_rv = 1'b1; m_done++; m_state = 4;
        end
    endtask

    // Clean press: well beyond sync + debounce time, then an equally long release
    task automatic press(input bit pa, input bit pb, input bit po,
                         input logic [9:0] d, input logic c);
        @(negedge clk);
        data_in = d; cin = c;
        a_pin = ~pa; b_pin = ~pb; op_pin = ~po;
        repeat (12) @(negedge clk);
        a_pin = 1'b1; b_pin = 1'b1; op_pin = 1'b1;
        repeat (12) @(negedge clk);
        model_apply(pa, pb, po, d, c);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        check({tag, ".done"}, 32'(done), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        a_pin = 1'b1; b_pin = 1'b1; op_pin = 1'b1; cin = 1'b0; data_in = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset arriving mid-debounce of an A press
        data_in = 10'h155;
        a_pin = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all("reset_mid_press");
        check("reset_mid_press.done", 32'(done), 32'(0));
        a_pin = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_all("after_reset_idle");
        press(1, 0, 0, 10'h155, 1'b0);
        check_all("fresh_a_press");

        // Full A/B/Op sequence
        press(1, 0, 0, 10'h005, 1'b0);
        press(0, 1, 0, 10'h003, 1'b0);
        press(0, 0, 1, 10'h002, 1'b1);
        check_all("full_seq");
        check("full_seq.result_const", 32'(result), 32'h0009);
        check("full_seq.flags_const", 32'(flags), 32'h02);

        // Restart from S_SHOW keeps the old result but drops valid
        press(1, 0, 0, 10'h010, 1'b0);
        check_all("restart");
        check("restart.result_held", 32'(result), 32'h0009);

        // A and B together in S_B: A wins, B is lost
        press(1, 1, 0, 10'h0AA, 1'b0);
        check_all("simultaneous");

        // Out-of-order presses in S_A are ignored
        do_reset("reset2");
        press(0, 1, 0, 10'h111, 1'b0);
        press(0, 0, 1, 10'h022, 1'b1);
        check_all("order_ignored");
        press(1, 0, 0, 10'h3FF, 1'b0);
        check_all("order_a_load");
        check("order_a_const", 32'(A), 32'h03FF);

        // Bouncing pin never settles long enough to register
        do_reset("reset3");
        data_in = 10'h077;
        for (int i = 0; i < 20; i++) begin
            a_pin = ~a_pin;
            repeat (2) @(negedge clk);
        end
        a_pin = 1'b1;
        repeat (12) @(negedge clk);
        check_all("bounce_no_load");

        // Long hold gives exactly one load; a switch change mid-hold must not reload A
        a_pin = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i == 30) data_in = 10'h100;
            @(negedge clk);
        end
        a_pin = 1'b1;
        repeat (12) @(negedge clk);
        model_apply(1, 0, 0, 10'h077, 1'b0);
        check_all("long_hold");

        // Random button sequences
        for (int n = 0; n < 60; n++) begin
            int unsigned kind;
            logic [9:0]  d;
            logic        c;
            kind = $urandom_range(0, 5);
            d    = 10'($urandom);
            c    = 1'($urandom);
            case (kind)
                0: press(1, 0, 0, d, c);
                1: press(0, 1, 0, d, c);
                2: press(0, 0, 1, d, c);
                3: press(1, 1, 0, d, c);
                4: press(0, 1, 1, d, c);
                default: press(0, 0, 1, d, c);
            endcase
            check_all($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Sequencer that sits between the board's push buttons/switches and the 16-bit ALU. It synchronizes and debounces the three buttons, loads operand A, operand B and the opcode from the 10 switches in a fixed order, and triggers one evaluation. It then captures the ALU result and flags into holding registers for the hex displays. The ALU stays purely combinational; this block owns all operand and result state.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button press or release (≥2; use ~500000 on board).
- BUTTON_ACTIVE_LOW, 1, 1 = button pin reads 0 when pressed.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- A_button, B_button, Op_button  in  1 each  raw, asynchronous push-button pins.
- cin  in  1  raw carry-in switch.
- data_in  in  10  raw switch bank.
- alu_out  in  16  ALU Output (combinational from A, B, Op, cin_q).
- alu_flags  in  5  ALU Flags.
- A, B  out  16  operand registers driven to the ALU.
- Op  out  8  opcode register driven to the ALU.
- cin_q  out  1  registered carry-in driven to the ALU.
- result  out  16  captured ALU output (display source).
- flags  out  5  captured ALU flags.
- result_valid  out  1  high while result/flags belong to the current operands.
- done  out  1  one-cycle pulse when a result is captured.
- state  out  3  current FSM state encoding.

## Operation
- Input conditioning: each button, cin and data_in pass through a 2-flop synchronizer. Inversion is applied when BUTTON_ACTIVE_LOW=1.
- Debounce, per button: counter of consecutive cycles where the synced level differs from the debounced level.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Any cycle where the levels agree clears the counter.
  - A released->pressed flip emits a one-cycle press pulse. Releases emit nothing.
  - Holding a button produces exactly one pulse.
- Widths: A and B load zero-extended {6'b0, data_in_sync}; Op loads data_in_sync[7:0]; cin_q loads cin_sync on the Op load.
- FSM states: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
  - A press in S_A, S_B, S_OP or S_SHOW: load A, clear result_valid, go to S_B.
  - B press in S_B: load B, go to S_OP. Ignored in any other state.
  - Op press in S_OP: load Op and cin_q, go to S_EXEC. Ignored in any other state.
  - S_EXEC, one cycle, unconditional: result<=alu_out, flags<=alu_flags, done=1, result_valid<=1, go to S_SHOW.
  - S_SHOW: hold all registers until an A press.
- Simultaneous pulses: priority A > B > Op. Only one action is taken per cycle; a lower-priority pulse in that cycle is lost.
- All presses are ignored in S_EXEC, since it lasts one cycle.
- Unused state encodings 5-7 return to S_A on the next cycle, without touching the registers.

## Timing
- Reset (async assert, any cycle, including mid-sequence): A=B=0, Op=0, cin_q=0, result=0, flags=0, result_valid=0, done=0, state=S_A.
  - Debouncers reset to the released level with counters at 0; synchronizers reset to the released level.
- Reset release: synchronous to clk.
- Press latency: the pin must be stable pressed for 2 sync cycles + DEBOUNCE_CYCLES before the pulse. The register load and state change occur at the clock edge ending the pulse cycle.
- Op load at edge N puts state=S_EXEC during cycle N+1. At edge N+1, result and flags are captured and state=S_SHOW. done is high during cycle N+1 only.
  - The ALU has one full cycle with stable operands before capture.
- data_in is sampled in the pulse cycle. Switch changes after that do not affect the loaded operand.
- result and flags change only at the S_EXEC edge and reset. result_valid falls on the A-load edge.

## Test plan
- Reset: with DEBOUNCE_CYCLES=4, assert rst_n=0 mid-count during an A press -> all outputs are 0 and state=0.
  - After release, a fresh A press of 6+ stable cycles is required to load A.
- Full sequence: data_in=0x005 + A press, 0x003 + B press, 0x002 + Op press (cin=1), with the ALU model returning 0x0009 and flags 5'b00010.
  - Required: A=0x0005, B=0x0003, Op=0x02, cin_q=1, a single done pulse, result=0x0009, flags=0x02, result_valid=1, state=4.
- Debounce: A pin toggling every 2 cycles for 40 cycles -> no load. Pin held low for 200 cycles -> exactly one load, state 0->1.
- Order enforcement: B press and Op press in S_A -> state stays 0 and B/Op remain 0.
  - Then an A press with data_in=0x3FF -> A=0x03FF, state=1.
- Simultaneous: A and B pulses in the same cycle while in S_B -> A reloads, B unchanged, state stays 1.
- Restart from S_SHOW: an A press with data_in=0x010 -> A=0x0010, result_valid=0, result holds its old value, state=1.
